// File: rtl/burst_pulse_gen_pkg.sv
// Shared sn74lib definitions for the burst pulse generator: state encodings,
// phase-timer sizing and the legal range of the HALF parameter.
package burst_pulse_gen_pkg;

    localparam int unsigned HALF_MIN = 1;
    localparam int unsigned HALF_MAX = 15;
    localparam int unsigned TIMER_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } bpg_state_t;

    // Phase timer reload value; out-of-range HALF is clamped to the legal range.
    function automatic logic [TIMER_W-1:0] half_reload(input int unsigned half);
        int unsigned h;
        h = half;
        if (h < HALF_MIN) h = HALF_MIN;
        if (h > HALF_MAX) h = HALF_MAX;
        return TIMER_W'(h - 1);
    endfunction

endpackage

// File: rtl/burst_phase_timer.sv
// Phase timer: loadable down-counter of HALF cycles with a terminal-count flag.
module burst_phase_timer
    import burst_pulse_gen_pkg::*;
#(
    parameter int unsigned HALF = 1
) (
    input  logic clk,
    input  logic clr_n,
    input  logic load,
    output logic tc_c
);

    localparam logic [TIMER_W-1:0] RELOAD = half_reload(HALF);

    logic [TIMER_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - TIMER_W'(1);
        end
    end

    // Last cycle of the current phase.
    assign tc_c = (cnt == '0);

endmodule

// File: rtl/burst_pulse_gen.sv
// Burst pulse generator: emits N low/high pulses of HALF cycles per phase,
// then a one-cycle done strobe. All outputs come straight from flops.
module burst_pulse_gen
    import burst_pulse_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned HALF  = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] count,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rem
);

    bpg_state_t state;
    logic       tc_c;
    logic       load_c;

    // Restart the phase timer on every entry into LOW or HIGH.
    always_comb begin
        load_c = 1'b0;
        case (state)
            ST_IDLE: load_c = start && (count != '0);
            ST_LOW:  load_c = tc_c;
            ST_HIGH: load_c = tc_c && (rem != '0);
            default: load_c = 1'b0;
        endcase
    end

    burst_phase_timer #(
        .HALF (HALF)
    ) u_timer (
        .clk   (clk),
        .clr_n (clr_n),
        .load  (load_c),
        .tc_c  (tc_c)
    );

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state <= ST_IDLE;
            pulse <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            rem   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            state <= ST_LOW;
                            rem   <= count - WIDTH'(1);
                            pulse <= 1'b0;
                            busy  <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_LOW: begin
                    if (tc_c) begin
                        state <= ST_HIGH;
                        pulse <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (tc_c) begin
                        // rem holds pulses not yet started, so it stops at zero.
                        if (rem != '0) begin
                            state <= ST_LOW;
                            rem   <= rem - WIDTH'(1);
                            pulse <= 1'b0;
                        end else begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    pulse <= 1'b1;
                    busy  <= 1'b0;
                    rem   <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    pulse <= 1'b1;
                    busy  <= 1'b0;
                    rem   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_pulse_gen.sv
// Bench for burst_pulse_gen: HALF=1 and HALF=2 instances share stimulus; a
// per-instance queue holds the expected output waveform for upcoming cycles.
module tb_burst_pulse_gen;

    typedef struct packed {
        logic       pulse;
        logic       busy;
        logic       done;
        logic [3:0] rem;
    } exp_t;

    localparam exp_t IDLE_E = '{pulse: 1'b1, busy: 1'b0, done: 1'b0, rem: 4'd0};
    localparam exp_t DONE_E = '{pulse: 1'b1, busy: 1'b0, done: 1'b1, rem: 4'd0};

    logic       clk = 1'b0;
    logic       clr_n;
    logic       start;
    logic [3:0] count;
    logic       pulse [2];
    logic       busy  [2];
    logic       done  [2];
    logic [3:0] rem   [2];

    exp_t q [2][$];
    int   errors = 0;
    int   checks = 0;
    int   falls  [2];
    int   busy_n [2];
    int   done_n [2];
    logic prev_p [2];

    logic       clr393;
    logic [3:0] q393;

    always #5 clk = ~clk;

    burst_pulse_gen #(.WIDTH(4), .HALF(1)) u_dut0 (
        .clk(clk), .clr_n(clr_n), .start(start), .count(count),
        .pulse(pulse[0]), .busy(busy[0]), .done(done[0]), .rem(rem[0])
    );

    burst_pulse_gen #(.WIDTH(4), .HALF(2)) u_dut1 (
        .clk(clk), .clr_n(clr_n), .start(start), .count(count),
        .pulse(pulse[1]), .busy(busy[1]), .done(done[1]), .rem(rem[1])
    );

    // SN74XX393-style ripple counter clocked by falling edges of pulse.
    always @(negedge pulse[0] or posedge clr393) begin
        if (clr393) q393 <= 4'd0;
        else        q393 <= q393 + 4'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_burst(input int d, input int n);
        int half;
        exp_t e;
        half = (d == 0) ? 1 : 2;
        for (int p = 0; p < n; p++) begin
            for (int h = 0; h < half; h++) begin
                e = '{pulse: 1'b0, busy: 1'b1, done: 1'b0, rem: 4'(n - 1 - p)};
                q[d].push_back(e);
            end
            for (int h = 0; h < half; h++) begin
                e = '{pulse: 1'b1, busy: 1'b1, done: 1'b0, rem: 4'(n - 1 - p)};
                q[d].push_back(e);
            end
        end
        q[d].push_back(DONE_E);
        q[d].push_back(IDLE_E);
    endtask

    // Drive one cycle of inputs, update expectations, then sample after the edge.
    task automatic step(input logic st, input logic [3:0] cn, input logic rn);
        exp_t e;
        exp_t got;
        start = st;
        count = cn;
        clr_n = rn;
        for (int d = 0; d < 2; d++) begin
            if (!rn) begin
                q[d].delete();
                q[d].push_back(IDLE_E);
            end else if (q[d].size() == 0) begin
                if (st) push_burst(d, int'(cn));
                else    q[d].push_back(IDLE_E);
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            got = '{pulse: pulse[d], busy: busy[d], done: done[d], rem: rem[d]};
            e = q[d].pop_front();
            check_eq($sformatf("outs dut%0d {pulse,busy,done,rem}", d), 32'(got), 32'(e));
            if (prev_p[d] === 1'b1 && pulse[d] === 1'b0) falls[d]++;
            if (busy[d] === 1'b1) busy_n[d]++;
            if (done[d] === 1'b1) done_n[d]++;
            prev_p[d] = pulse[d];
        end
    endtask

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            falls[d]  = 0;
            busy_n[d] = 0;
            done_n[d] = 0;
        end
        clr393 = 1'b1;
        #1;
        clr393 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (q[0].size() != 0 || q[1].size() != 0); i++)
            step(1'b0, 4'd0, 1'b1);
        check_eq("drain dut0 queue", 32'(q[0].size()), 32'd0);
        check_eq("drain dut1 queue", 32'(q[1].size()), 32'd0);
    endtask

    initial begin
        clr393 = 1'b0;
        prev_p[0] = 1'b1;
        prev_p[1] = 1'b1;
        start = 1'b0;
        count = 4'd0;
        clr_n = 1'b0;
        clear_stats();

        // Reset, with start asserted to show it is ignored under reset.
        step(1'b1, 4'd3, 1'b0);
        step(1'b1, 4'd3, 1'b0);
        step(1'b0, 4'd0, 1'b1);

        // Five pulses.
        clear_stats();
        step(1'b1, 4'd5, 1'b1);
        drain();
        check_eq("393 after 5 pulses", 32'(q393), 32'd5);
        check_eq("busy cycles dut0 n=5", 32'(busy_n[0]), 32'd10);
        check_eq("busy cycles dut1 n=5", 32'(busy_n[1]), 32'd20);
        check_eq("falls dut1 n=5", 32'(falls[1]), 32'd5);
        check_eq("done count dut0 n=5", 32'(done_n[0]), 32'd1);

        // Zero-length burst.
        clear_stats();
        step(1'b1, 4'd0, 1'b1);
        drain();
        check_eq("busy cycles n=0", 32'(busy_n[0] + busy_n[1]), 32'd0);
        check_eq("falls n=0", 32'(falls[0] + falls[1]), 32'd0);
        check_eq("done count dut0 n=0", 32'(done_n[0]), 32'd1);

        // Largest burst.
        clear_stats();
        step(1'b1, 4'd15, 1'b1);
        drain();
        check_eq("busy cycles dut1 n=15", 32'(busy_n[1]), 32'd60);
        check_eq("falls dut1 n=15", 32'(falls[1]), 32'd15);
        check_eq("done count dut1 n=15", 32'(done_n[1]), 32'd1);
        check_eq("busy cycles dut0 n=15", 32'(busy_n[0]), 32'd30);

        // Re-start and count changes mid-burst are ignored.
        clear_stats();
        step(1'b1, 4'd5, 1'b1);
        step(1'b0, 4'd9, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 4'd12, 1'b1);
        drain();
        check_eq("falls dut0 restart ignored", 32'(falls[0]), 32'd5);
        check_eq("falls dut1 restart ignored", 32'(falls[1]), 32'd5);
        check_eq("done count dut0 restart", 32'(done_n[0]), 32'd1);

        // Reset during the third pulse aborts without done.
        clear_stats();
        step(1'b1, 4'd5, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b0);
        check_eq("done after abort", 32'(done_n[0] + done_n[1]), 32'd0);
        check_eq("falls dut0 before abort", 32'(falls[0]), 32'd3);
        // First edge after release accepts start.
        step(1'b1, 4'd2, 1'b1);
        check_eq("start after release", 32'({pulse[0], busy[0]}), 32'b01);
        drain();

        // Start held high: back-to-back bursts of three.
        clear_stats();
        for (int i = 0; i < 40; i++) step(1'b1, 4'd3, 1'b1);
        drain();
        check_eq("falls dut0 held start", 32'(falls[0]), 32'(3 * done_n[0]));
        check_eq("bursts dut0 held start", 32'(done_n[0]), 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
